ram_port_responder: RTL and testbench

//  Memory-side end of the core RAM port: services read requests (ADDR/RR -> ACK/data)
//  and write requests (ADDR/DATA/WR -> ACCESS) issued by a core's RAM controller.

---
 rtl/ram_port_responder_pkg.sv | 24 ++
 rtl/ram_byte_array.sv | 23 ++
 rtl/ram_port_responder.sv | 143 ++++++++++++++
 tb/tb_ram_port_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_responder_pkg.sv
// Shared definitions for the core RAM port: bus widths, latency counter width,
// responder state encoding and the write-request payload.
package ram_port_responder_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_ACK  = 3'd2,
    ST_RD_REL  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_ACK  = 3'd5,
    ST_WR_REL  = 3'd6
  } state_t;

  typedef struct packed {
    logic [BUS_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } ram_wr_req_t;

endpackage

// File: rtl/ram_byte_array.sv
// Single-port synchronous byte RAM with registered read and write enable.
module ram_byte_array
  import ram_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_port_responder.sv
// Memory-side responder of the core RAM port: 4-phase read/write handshakes
// serviced one at a time against a local byte RAM.
module ram_port_responder
  import ram_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned WRITE_LAT = 1,
  parameter bit          WR_FIRST  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [BUS_W-1:0]  RAMRESPONDER_InDataADDR,
  input  logic              RAMRESPONDER_InDataRR,
  output logic              RAMRESPONDER_InDataACK,
  output logic [DATA_W-1:0] RAMRESPONDER_InData,
  input  logic [BUS_W-1:0]  RAMRESPONDER_OutDataADDR,
  input  logic [DATA_W-1:0] RAMRESPONDER_OutData,
  input  logic              RAMRESPONDER_OutDataWR,
  output logic              RAMRESPONDER_OutDataACCESS,
  output logic              RAMRESPONDER_Busy,
  output logic              RAMRESPONDER_ProtoErr
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] indata_d;
  logic              ack_d, access_d, busy_d, err_d;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_rdata;
  ram_wr_req_t       wr_req_c;
  logic              rr, wr;

  assign rr       = RAMRESPONDER_InDataRR;
  assign wr       = RAMRESPONDER_OutDataWR;
  assign wr_req_c = '{addr: RAMRESPONDER_OutDataADDR, data: RAMRESPONDER_OutData};

  // Upper address bits alias onto the implemented depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{RAMRESPONDER_InDataADDR[BUS_W-1:ADDR_W],
                            wr_req_c.addr[BUS_W-1:ADDR_W]};

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    indata_d = RAMRESPONDER_InData;
    err_d    = RAMRESPONDER_ProtoErr;
    ack_d    = 1'b0;
    access_d = 1'b0;
    ram_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr && (!rr || WR_FIRST)) begin
          state_d = ST_WR_WAIT;
          cnt_d   = CNT_W'(WRITE_LAT);
          addr_d  = wr_req_c.addr[ADDR_W-1:0];
          wdata_d = wr_req_c.data;
        end else if (rr) begin
          state_d = ST_RD_WAIT;
          cnt_d   = CNT_W'(READ_LAT);
          addr_d  = RAMRESPONDER_InDataADDR[ADDR_W-1:0];
        end
      end
      ST_RD_WAIT: begin
        if (!rr) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_RD_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD_ACK: begin
        ack_d    = 1'b1;
        indata_d = ram_rdata;
        state_d  = ST_RD_REL;
      end
      ST_RD_REL: begin
        if (!rr) state_d = ST_IDLE;
      end
      ST_WR_WAIT: begin
        if (!wr) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_WR_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_ACK: begin
        ram_we_c = 1'b1;
        access_d = 1'b1;
        state_d  = ST_WR_REL;
      end
      ST_WR_REL: begin
        if (!wr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q                    <= ST_IDLE;
      cnt_q                      <= '0;
      addr_q                     <= '0;
      wdata_q                    <= '0;
      RAMRESPONDER_InDataACK     <= 1'b0;
      RAMRESPONDER_InData        <= '0;
      RAMRESPONDER_OutDataACCESS <= 1'b0;
      RAMRESPONDER_Busy          <= 1'b0;
      RAMRESPONDER_ProtoErr      <= 1'b0;
    end else begin
      state_q                    <= state_d;
      cnt_q                      <= cnt_d;
      addr_q                     <= addr_d;
      wdata_q                    <= wdata_d;
      RAMRESPONDER_InDataACK     <= ack_d;
      RAMRESPONDER_InData        <= indata_d;
      RAMRESPONDER_OutDataACCESS <= access_d;
      RAMRESPONDER_Busy          <= busy_d;
      RAMRESPONDER_ProtoErr      <= err_d;
    end
  end

  // A reset landing on the write cycle must not disturb memory.
  ram_byte_array #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .we    (ram_we_c && !RST),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_ram_port_responder.sv
// Randomized self-checking bench for ram_port_responder against a byte-array
// reference model of the port's handshake timing and memory contents.
module tb_ram_port_responder;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int unsigned READ_LAT  = 1;
  localparam int unsigned WRITE_LAT = 4;
  localparam int          BUDGET    = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rd_addr, wr_addr;
  logic        rr, wr;
  logic [7:0]  wr_data;
  logic        ack, access, busy, proto_err;
  logic [7:0]  indata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_m [DEPTH];
  logic [7:0] indata_m;
  logic       err_m;
  logic [15:0] written_q [$];

  always #5 clk = ~clk;

  ram_port_responder #(
    .ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .WR_FIRST(1'b1)
  ) dut (
    .CLK                        (clk),
    .RST                        (rst),
    .RAMRESPONDER_InDataADDR    (rd_addr),
    .RAMRESPONDER_InDataRR      (rr),
    .RAMRESPONDER_InDataACK     (ack),
    .RAMRESPONDER_InData        (indata),
    .RAMRESPONDER_OutDataADDR   (wr_addr),
    .RAMRESPONDER_OutData       (wr_data),
    .RAMRESPONDER_OutDataWR     (wr),
    .RAMRESPONDER_OutDataACCESS (access),
    .RAMRESPONDER_Busy          (busy),
    .RAMRESPONDER_ProtoErr      (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned idx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  // Advance one clock and sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < BUDGET) begin
      next_cycle();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    int  edges = 0;
    bit  seen  = 1'b0;
    wr_addr = a; wr_data = d; wr = 1'b1;
    while (!seen && edges < BUDGET) begin
      next_cycle();
      edges++;
      check("wr_no_ack", 32'(ack), 32'd0);
      seen = access;
    end
    check("wr_latency", 32'(edges), 32'(3 + WRITE_LAT));
    mem_m[idx(a)] = d;
    written_q.push_back(a);
    wr_addr = 16'($urandom); wr_data = 8'($urandom);
    next_cycle();
    check("wr_single_pulse", 32'(access), 32'd0);
    check("wr_busy_rel", 32'(busy), 32'd1);
    wr = 1'b0;
    wait_idle("wr");
  endtask

  task automatic do_read(input logic [15:0] a, input int hold);
    int  edges = 0;
    bit  seen  = 1'b0;
    rd_addr = a; rr = 1'b1;
    while (!seen && edges < BUDGET) begin
      next_cycle();
      edges++;
      check("rd_no_access", 32'(access), 32'd0);
      seen = ack;
    end
    check("rd_latency", 32'(edges), 32'(3 + READ_LAT));
    indata_m = mem_m[idx(a)];
    check("rd_data", 32'(indata), 32'(indata_m));
    rd_addr = 16'($urandom);
    for (int i = 0; i < hold; i++) begin
      next_cycle();
      check("rd_hold_no_ack", 32'(ack), 32'd0);
      check("rd_hold_busy", 32'(busy), 32'd1);
    end
    next_cycle();
    check("rd_single_pulse", 32'(ack), 32'd0);
    check("rd_data_held", 32'(indata), 32'(indata_m));
    rr = 1'b0;
    wait_idle("rd");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rr = 1'b0; wr = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    indata_m = 8'h00; err_m = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 8'h00;
    @(negedge clk);
    next_cycle();
    next_cycle();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_access", 32'(access), 32'd0);
    check("rst_indata", 32'(indata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    next_cycle();

    // Basic write then read, then a read held well past its ACK.
    do_write(16'h0012, 8'hA5);
    do_read(16'h0012, 0);
    do_read(16'h0012, 10);

    // Address aliasing onto the implemented depth.
    do_write(16'h0400, 8'h3C);
    do_read(16'h0000, 0);

    // Simultaneous requests: write wins, read follows and sees new byte.
    begin
      int  edges = 0;
      bit  seen  = 1'b0;
      rd_addr = 16'h0055; wr_addr = 16'h0055; wr_data = 8'h7E;
      rr = 1'b1; wr = 1'b1;
      while (!seen && edges < BUDGET) begin
        next_cycle();
        edges++;
        check("both_no_ack", 32'(ack), 32'd0);
        seen = access;
      end
      check("both_wr_latency", 32'(edges), 32'(3 + WRITE_LAT));
      mem_m[idx(16'h0055)] = 8'h7E;
      written_q.push_back(16'h0055);
      next_cycle();
      wr = 1'b0;
      seen = 1'b0; edges = 0;
      while (!seen && edges < BUDGET) begin
        next_cycle();
        edges++;
        check("both_no_access", 32'(access), 32'd0);
        seen = ack;
      end
      check("both_rd_seen", 32'(seen), 32'd1);
      indata_m = 8'h7E;
      check("both_rd_data", 32'(indata), 32'(indata_m));
      rr = 1'b0;
      next_cycle();
      wait_idle("both");
    end

    // Write request dropped mid-wait: aborted, memory untouched, error latched.
    do_write(16'h0033, 8'h11);
    wr_addr = 16'h0033; wr_data = 8'hEE; wr = 1'b1;
    next_cycle();
    next_cycle();
    wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("drop_no_access", 32'(access), 32'd0);
    end
    err_m = 1'b1;
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_err", 32'(proto_err), 32'(err_m));
    do_read(16'h0033, 0);

    // Reset during a read wait: no ACK, idle at once, memory preserved.
    do_write(16'h0200, 8'h5A);
    rd_addr = 16'h0200; rr = 1'b1;
    next_cycle();
    rst = 1'b1; rr = 1'b0;
    next_cycle();
    err_m = 1'b0; indata_m = 8'h00;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_indata", 32'(indata), 32'(indata_m));
    check("mid_rst_err", 32'(proto_err), 32'(err_m));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      check("post_rst_no_ack", 32'(ack), 32'd0);
    end
    do_read(16'h0200, 0);

    // Random mix of writes and aliased reads of previously written bytes.
    for (int n = 0; n < 40; n++) begin
      if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
        do_write(16'($urandom), 8'($urandom));
      end else begin
        logic [15:0] a;
        a = written_q[$urandom_range(0, written_q.size() - 1)];
        a = 16'(idx(a)) | 16'(($urandom_range(0, 63)) << ADDR_W);
        do_read(a, int'($urandom_range(0, 3)));
      end
    end
    check("final_err", 32'(proto_err), 32'(err_m));
    check("final_indata", 32'(indata), 32'(indata_m));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
